// File: rtl/am2910_fetch_ctrl.sv
// Run/halt and control-store fetch controller for an am2910 microprogram sequencer.
// Each microword is fetched over a request/valid handshake, then applied for one advance cycle.
//
// state   | meaning
// IDLE    | powered down, sequencer output disabled, waiting for START
// INIT    | one cycle of JZ with carry-in to point the sequencer at address 0
// FETCH   | control-store request outstanding at CS_ADDR, timeout running
// EXEC    | pipelined word drives the sequencer for exactly one advance
// HALTED  | sequencer frozen, waiting for START (resume) or STEP
// ERROR   | fetch timed out; only reset leaves
module am2910_fetch_ctrl #(
  parameter int CW_WIDTH  = 32,
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   CP,
  input  logic                   RESET,
  input  logic                   START,
  input  logic                   HALT_REQ,
  input  logic                   STEP,
  input  logic [11:0]            Y_IN,
  output logic [3:0]             SEQ_I,
  output logic [11:0]            SEQ_D,
  output logic                   SEQ_CCEN,
  output logic                   SEQ_RLD,
  output logic                   SEQ_CI,
  output logic                   SEQ_OE,
  output logic                   CS_REQ,
  output logic [11:0]            CS_ADDR,
  input  logic [CW_WIDTH-1:0]    CS_DATA,
  input  logic                   CS_VALID,
  output logic [CW_WIDTH-20:0]   CTRL,
  output logic                   CTRL_STB,
  output logic                   BUSY,
  output logic                   HALTED,
  output logic                   ERR,
  output logic [CNT_WIDTH-1:0]   EXEC_CNT
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [3:0] I_JZ   = 4'h0;
  localparam logic [3:0] I_CONT = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FETCH,
    S_EXEC,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW_WIDTH-1:0]   pipe;
  logic [11:0]           cs_addr;
  logic                  step_mode;
  logic [TW-1:0]         tmo_cnt;
  logic [CNT_WIDTH-1:0]  exec_cnt;

  always_ff @(posedge CP or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START) state_nxt = S_INIT;
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (CS_VALID)          state_nxt = S_EXEC;
        else if (tmo_cnt == '0) state_nxt = S_ERROR;
      end
      S_EXEC: begin
        // A stepped word always returns to HALTED, whatever its HALT bit says.
        if (pipe[18] || HALT_REQ || step_mode) state_nxt = S_HALTED;
        else                                   state_nxt = S_FETCH;
      end
      S_HALTED: if (START || STEP) state_nxt = S_FETCH;
      S_ERROR:  state_nxt = S_ERROR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CP or posedge RESET) begin
    if (RESET) begin
      pipe      <= '0;
      cs_addr   <= '0;
      step_mode <= 1'b0;
      tmo_cnt   <= '0;
      exec_cnt  <= '0;
    end else begin
      if (state == S_FETCH && CS_VALID) pipe <= CS_DATA;
      if (state == S_INIT || state == S_EXEC) cs_addr <= Y_IN;
      if (state == S_EXEC) exec_cnt <= exec_cnt + CNT_WIDTH'(1);
      // Reloaded in every non-FETCH cycle so each FETCH entry starts a fresh timeout.
      if (state == S_FETCH) begin
        if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - TW'(1);
      end else begin
        tmo_cnt <= TMO_LOAD;
      end
      if (state == S_HALTED) begin
        if (START)     step_mode <= 1'b0;
        else if (STEP) step_mode <= 1'b1;
      end else if (state == S_IDLE) begin
        step_mode <= 1'b0;
      end
    end
  end

  always_comb begin
    SEQ_I    = I_CONT;
    SEQ_D    = '0;
    SEQ_CCEN = 1'b1;
    SEQ_RLD  = 1'b1;
    SEQ_CI   = 1'b0;
    case (state)
      S_INIT: begin
        SEQ_I  = I_JZ;
        SEQ_CI = 1'b1;
      end
      S_EXEC: begin
        SEQ_I    = pipe[3:0];
        SEQ_D    = pipe[15:4];
        SEQ_CCEN = pipe[16];
        SEQ_RLD  = pipe[17];
        SEQ_CI   = 1'b1;
      end
      default: ;
    endcase
  end

  assign SEQ_OE   = (state == S_IDLE);
  assign CS_REQ   = (state == S_FETCH);
  assign CS_ADDR  = cs_addr;
  assign CTRL     = pipe[CW_WIDTH-1:19];
  assign CTRL_STB = (state == S_EXEC);
  assign BUSY     = (state == S_INIT) || (state == S_FETCH) || (state == S_EXEC);
  assign HALTED   = (state == S_HALTED);
  assign ERR      = (state == S_ERROR);
  assign EXEC_CNT = exec_cnt;

endmodule

// File: tb/tb_am2910_fetch_ctrl.sv
// Directed bench for am2910_fetch_ctrl with a minimal am2910 model (JZ/JP/CONT)
// and a control store answering after a programmable number of wait cycles.
module tb_am2910_fetch_ctrl;
  localparam int CW  = 32;
  localparam int CNT = 4;   // narrow counter so wrap-around is reachable quickly

  logic            CP, RESET, START, HALT_REQ, STEP;
  logic [11:0]     Y_IN;
  logic [3:0]      SEQ_I;
  logic [11:0]     SEQ_D;
  logic            SEQ_CCEN, SEQ_RLD, SEQ_CI, SEQ_OE;
  logic            CS_REQ;
  logic [11:0]     CS_ADDR;
  logic [CW-1:0]   CS_DATA;
  logic            CS_VALID;
  logic [CW-20:0]  CTRL;
  logic            CTRL_STB, BUSY, HALTED, ERR;
  logic [CNT-1:0]  EXEC_CNT;

  int checks = 0;
  int passed = 0;

  logic [CW-1:0] mem [0:4095];
  int   wait_n = 0;
  logic no_resp = 1'b0;
  int   wcnt = 0;
  logic [11:0] upc;

  am2910_fetch_ctrl #(.CW_WIDTH(CW), .TIMEOUT(255), .CNT_WIDTH(CNT)) dut (
    .CP(CP), .RESET(RESET), .START(START), .HALT_REQ(HALT_REQ), .STEP(STEP),
    .Y_IN(Y_IN), .SEQ_I(SEQ_I), .SEQ_D(SEQ_D), .SEQ_CCEN(SEQ_CCEN), .SEQ_RLD(SEQ_RLD),
    .SEQ_CI(SEQ_CI), .SEQ_OE(SEQ_OE), .CS_REQ(CS_REQ), .CS_ADDR(CS_ADDR),
    .CS_DATA(CS_DATA), .CS_VALID(CS_VALID), .CTRL(CTRL), .CTRL_STB(CTRL_STB),
    .BUSY(BUSY), .HALTED(HALTED), .ERR(ERR), .EXEC_CNT(EXEC_CNT)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  // Sequencer model: uPC advances by CI each clock from the selected Y.
  assign Y_IN = (SEQ_I == 4'h0) ? 12'h000 : (SEQ_I == 4'h3) ? SEQ_D : upc;
  always @(posedge CP or posedge RESET) begin
    if (RESET) upc <= 12'h000;
    else       upc <= Y_IN + {11'b0, SEQ_CI};
  end

  // Control store: answers after wait_n request cycles; junk data otherwise.
  initial begin
    CS_VALID = 1'b0;
    CS_DATA  = '1;
    forever begin
      @(negedge CP);
      if (CS_REQ && !no_resp) begin
        if (wcnt >= wait_n) begin
          CS_VALID = 1'b1;
          CS_DATA  = mem[CS_ADDR];
        end else begin
          CS_VALID = 1'b0;
          CS_DATA  = '1;
          wcnt++;
        end
      end else begin
        CS_VALID = 1'b0;
        CS_DATA  = '1;
        wcnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [CW-1:0] cw(input logic [3:0] i, input logic [11:0] d,
                                       input logic halt, input logic [12:0] user);
    return {user, halt, 1'b1, 1'b1, d, i};
  endfunction

  function automatic logic [12:0] usr(input int a);
    return 13'h1000 + 13'(a);
  endfunction

  task automatic load_cont();
    for (int a = 0; a < 4096; a++) mem[a] = cw(4'hE, 12'h000, 1'b0, usr(a));
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CP);
    RESET = 1'b1; START = 1'b0; STEP = 1'b0; HALT_REQ = 1'b0; no_resp = 1'b0;
    repeat (2) @(negedge CP);
    RESET = 1'b0;
    #1;
  endtask

  task automatic pulse_start();
    @(negedge CP);
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset();
    load_cont();
    do_reset();
    checks++; if (SEQ_I !== 4'hE) $display("FAIL rst_seq_i: got %h want e", SEQ_I); else passed++;
    checks++; if (SEQ_CI !== 1'b0) $display("FAIL rst_seq_ci: got %b want 0", SEQ_CI); else passed++;
    checks++; if ({SEQ_RLD, SEQ_CCEN} !== 2'b11) $display("FAIL rst_rld_ccen: got %b want 11", {SEQ_RLD, SEQ_CCEN}); else passed++;
    checks++; if (SEQ_D !== 12'h000) $display("FAIL rst_seq_d: got %h want 000", SEQ_D); else passed++;
    checks++; if (SEQ_OE !== 1'b1) $display("FAIL rst_seq_oe: got %b want 1", SEQ_OE); else passed++;
    checks++; if (CS_REQ !== 1'b0) $display("FAIL rst_cs_req: got %b want 0", CS_REQ); else passed++;
    checks++; if (CS_ADDR !== 12'h000) $display("FAIL rst_cs_addr: got %h want 000", CS_ADDR); else passed++;
    checks++; if ({CTRL_STB, ERR, BUSY, HALTED} !== 4'b0000) $display("FAIL rst_flags: got %b want 0000", {CTRL_STB, ERR, BUSY, HALTED}); else passed++;
    checks++; if (EXEC_CNT !== 4'd0) $display("FAIL rst_exec_cnt: got %0d want 0", EXEC_CNT); else passed++;
    checks++; if (CTRL !== 13'h0000) $display("FAIL rst_ctrl: got %h want 0000", CTRL); else passed++;
    // STEP and HALT_REQ in IDLE do nothing
    @(negedge CP); STEP = 1'b1; HALT_REQ = 1'b1;
    tick(); tick();
    STEP = 1'b0; HALT_REQ = 1'b0;
    checks++; if ({BUSY, HALTED, SEQ_OE} !== 3'b001) $display("FAIL idle_ignore: got %b want 001", {BUSY, HALTED, SEQ_OE}); else passed++;
  endtask

  task automatic test_run();
    load_cont();
    do_reset();
    pulse_start();
    checks++; if ({SEQ_I, SEQ_CI} !== {4'h0, 1'b1}) $display("FAIL init_drive: got %h/%b want 0/1", SEQ_I, SEQ_CI); else passed++;
    checks++; if ({BUSY, SEQ_OE, CS_REQ} !== 3'b100) $display("FAIL init_flags: got %b want 100", {BUSY, SEQ_OE, CS_REQ}); else passed++;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (CS_ADDR !== 12'(k)) $display("FAIL run_addr%0d: got %h want %h", k, CS_ADDR, 12'(k)); else passed++;
      checks++; if ({CS_REQ, SEQ_I, SEQ_CI} !== {1'b1, 4'hE, 1'b0}) $display("FAIL run_fetch_hold%0d: got %b/%h/%b want 1/e/0", k, CS_REQ, SEQ_I, SEQ_CI); else passed++;
      tick();
      checks++; if ({CTRL_STB, SEQ_CI, CS_REQ} !== 3'b110) $display("FAIL run_exec%0d: got %b want 110", k, {CTRL_STB, SEQ_CI, CS_REQ}); else passed++;
      checks++; if (CTRL !== usr(k)) $display("FAIL run_ctrl%0d: got %h want %h", k, CTRL, usr(k)); else passed++;
      tick();
    end
    checks++; if (EXEC_CNT !== 4'd3) $display("FAIL run_cnt: got %0d want 3", EXEC_CNT); else passed++;
    checks++; if (CS_ADDR !== 12'h003) $display("FAIL run_addr3: got %h want 003", CS_ADDR); else passed++;
  endtask

  task automatic test_jump();
    int stb_cnt;
    logic stb_prev, stb_double;
    load_cont();
    mem[5]     = cw(4'h3, 12'h040, 1'b0, 13'h00AA);
    mem[12'h40] = cw(4'hE, 12'h000, 1'b1, 13'h00BB);
    do_reset();
    pulse_start();
    tick();
    stb_cnt = 0; stb_prev = 1'b0; stb_double = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (CTRL_STB) begin
          stb_cnt++;
          if (stb_prev) stb_double = 1'b1;
        end
        stb_prev = CTRL_STB;
        if (k == 5 && c == 1) begin
          checks++; if ({SEQ_I, SEQ_D} !== {4'h3, 12'h040}) $display("FAIL jp_drive: got %h/%h want 3/040", SEQ_I, SEQ_D); else passed++;
        end
        tick();
      end
    end
    checks++; if (stb_cnt !== 6) $display("FAIL jp_stb_count: got %0d want 6", stb_cnt); else passed++;
    checks++; if (stb_double !== 1'b0) $display("FAIL jp_stb_width: got %b want 0", stb_double); else passed++;
    checks++; if ({CS_REQ, CS_ADDR} !== {1'b1, 12'h040}) $display("FAIL jp_target: got %b/%h want 1/040", CS_REQ, CS_ADDR); else passed++;
    tick(); tick();
    checks++; if ({HALTED, CS_ADDR} !== {1'b1, 12'h041}) $display("FAIL jp_halt: got %b/%h want 1/041", HALTED, CS_ADDR); else passed++;
    checks++; if (CTRL !== 13'h00BB) $display("FAIL jp_ctrl: got %h want 00bb", CTRL); else passed++;
  endtask

  task automatic test_wait();
    int n, reqc;
    logic ctrl_bad;
    load_cont();
    do_reset();
    wait_n = 3;
    pulse_start();
    tick();
    n = 0; reqc = 0;
    while (!CTRL_STB && n < 20) begin
      if (CS_REQ) reqc++;
      tick();
      n++;
    end
    checks++; if (n !== 4) $display("FAIL wait_first: got %0d cycles want 4", n); else passed++;
    checks++; if (reqc !== 4) $display("FAIL wait_req_len: got %0d want 4", reqc); else passed++;
    n = 0; ctrl_bad = 1'b0;
    do begin
      tick();
      n++;
      if (CS_REQ && CTRL !== usr(0)) ctrl_bad = 1'b1;
    end while (!CTRL_STB && n < 20);
    checks++; if (n !== 5) $display("FAIL wait_period: got %0d cycles want 5", n); else passed++;
    checks++; if (ctrl_bad !== 1'b0) $display("FAIL wait_pipe_hold: got %b want 0", ctrl_bad); else passed++;
    checks++; if (CTRL !== usr(1)) $display("FAIL wait_ctrl1: got %h want %h", CTRL, usr(1)); else passed++;
    wait_n = 0;
  endtask

  task automatic test_halt_step();
    load_cont();
    mem[2] = cw(4'hE, 12'h000, 1'b1, usr(2));
    do_reset();
    pulse_start();
    repeat (7) tick();
    checks++; if ({HALTED, BUSY, CS_ADDR} !== {2'b10, 12'h003}) $display("FAIL halt_bit: got %b%b/%h want 10/003", HALTED, BUSY, CS_ADDR); else passed++;
    checks++; if (EXEC_CNT !== 4'd3) $display("FAIL halt_cnt: got %0d want 3", EXEC_CNT); else passed++;
    checks++; if ({SEQ_I, SEQ_CI, SEQ_OE} !== {4'hE, 2'b00}) $display("FAIL halt_hold: got %h/%b/%b want e/0/0", SEQ_I, SEQ_CI, SEQ_OE); else passed++;
    tick(); tick();
    checks++; if ({HALTED, CS_ADDR} !== {1'b1, 12'h003}) $display("FAIL halt_stays: got %b/%h want 1/003", HALTED, CS_ADDR); else passed++;
    @(negedge CP); STEP = 1'b1;
    tick();
    STEP = 1'b0;
    checks++; if ({CS_REQ, CS_ADDR} !== {1'b1, 12'h003}) $display("FAIL step_fetch: got %b/%h want 1/003", CS_REQ, CS_ADDR); else passed++;
    tick(); tick();
    checks++; if ({HALTED, CS_ADDR} !== {1'b1, 12'h004}) $display("FAIL step_done: got %b/%h want 1/004", HALTED, CS_ADDR); else passed++;
    checks++; if (EXEC_CNT !== 4'd4) $display("FAIL step_cnt: got %0d want 4", EXEC_CNT); else passed++;
    pulse_start();
    tick(); tick();
    checks++; if ({CS_REQ, HALTED, CS_ADDR} !== {2'b10, 12'h005}) $display("FAIL resume: got %b%b/%h want 10/005", CS_REQ, HALTED, CS_ADDR); else passed++;
    HALT_REQ = 1'b1;
    tick(); tick();
    HALT_REQ = 1'b0;
    checks++; if ({HALTED, CS_ADDR} !== {1'b1, 12'h006}) $display("FAIL halt_req: got %b/%h want 1/006", HALTED, CS_ADDR); else passed++;
    @(negedge CP); START = 1'b1; STEP = 1'b1;
    tick();
    START = 1'b0; STEP = 1'b0;
    tick(); tick();
    checks++; if ({CS_REQ, HALTED, CS_ADDR} !== {2'b10, 12'h007}) $display("FAIL start_wins: got %b%b/%h want 10/007", CS_REQ, HALTED, CS_ADDR); else passed++;
  endtask

  task automatic test_wrap();
    load_cont();
    do_reset();
    pulse_start();
    tick();
    repeat (32) tick();
    checks++; if ({EXEC_CNT, CS_ADDR} !== {4'd0, 12'h010}) $display("FAIL wrap_zero: got %0d/%h want 0/010", EXEC_CNT, CS_ADDR); else passed++;
    tick(); tick();
    checks++; if (EXEC_CNT !== 4'd1) $display("FAIL wrap_one: got %0d want 1", EXEC_CNT); else passed++;
  endtask

  task automatic test_timeout();
    load_cont();
    do_reset();
    no_resp = 1'b1;
    pulse_start();
    tick();
    repeat (254) tick();
    checks++; if ({CS_REQ, ERR} !== 2'b10) $display("FAIL tmo_last_fetch: got %b want 10", {CS_REQ, ERR}); else passed++;
    tick();
    checks++; if ({ERR, BUSY, CS_REQ, SEQ_OE} !== 4'b1000) $display("FAIL tmo_error: got %b want 1000", {ERR, BUSY, CS_REQ, SEQ_OE}); else passed++;
    checks++; if ({SEQ_I, SEQ_CI} !== {4'hE, 1'b0}) $display("FAIL tmo_hold: got %h/%b want e/0", SEQ_I, SEQ_CI); else passed++;
    pulse_start();
    tick();
    checks++; if ({ERR, BUSY, CS_REQ} !== 3'b100) $display("FAIL tmo_start_ignored: got %b want 100", {ERR, BUSY, CS_REQ}); else passed++;
    do_reset();
    checks++; if (ERR !== 1'b0) $display("FAIL tmo_reset_clears: got %b want 0", ERR); else passed++;
  endtask

  task automatic test_mid_fetch_reset();
    load_cont();
    do_reset();
    pulse_start();
    repeat (5) tick();
    no_resp = 1'b1;
    checks++; if ({CS_REQ, EXEC_CNT} !== {1'b1, 4'd2}) $display("FAIL mid_pre: got %b/%0d want 1/2", CS_REQ, EXEC_CNT); else passed++;
    tick();
    #3;
    RESET = 1'b1;
    #1;
    checks++; if (CS_REQ !== 1'b0) $display("FAIL mid_req_async: got %b want 0", CS_REQ); else passed++;
    checks++; if ({SEQ_OE, BUSY, EXEC_CNT} !== {2'b10, 4'd0}) $display("FAIL mid_state: got %b%b/%0d want 10/0", SEQ_OE, BUSY, EXEC_CNT); else passed++;
    checks++; if ({CS_ADDR, CTRL} !== 25'd0) $display("FAIL mid_regs: got %h/%h want 000/0000", CS_ADDR, CTRL); else passed++;
    @(negedge CP);
    RESET = 1'b0;
    no_resp = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; STEP = 1'b0; HALT_REQ = 1'b0;
    test_reset();
    test_run();
    test_jump();
    test_wait();
    test_halt_step();
    test_wrap();
    test_timeout();
    test_mid_fetch_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/am2910_fetch_ctrl.md
Name: am2910_fetch_ctrl

Overview:
Run/halt and control-store fetch controller that sequences the am2910 microprogram sequencer.
- Fetches each microword from the external control store with a valid/request handshake, holding the word in an internal pipeline register.
- Applies the word's sequencer fields (I, D, CCEN, RLD) for exactly one advance cycle.
- Freezes the sequencer between advances.
- Provides start, halt, single-step, fetch-timeout and an executed-instruction counter.

Parameters:
CW_WIDTH, 32, microword width. Layout: [3:0] I, [15:4] D, [16] CCEN, [17] RLD, [18] HALT bit, [CW_WIDTH-1:19] user control field.
TIMEOUT, 255, maximum FETCH cycles waiting for CS_VALID before error.
CNT_WIDTH, 16, width of the executed-instruction counter.

Ports:
CP  input  1  clock, rising edge
RESET  input  1  asynchronous reset, active-high
START  input  1  pulse: IDLE→INIT, or HALTED→FETCH (resume)
HALT_REQ  input  1  level: halt after the current EXEC
STEP  input  1  pulse in HALTED: execute exactly one microword
Y_IN  input  12  sequencer Y output (next microaddress)
SEQ_I  output  4  sequencer instruction
SEQ_D  output  12  sequencer D input
SEQ_CCEN  output  1  sequencer CCEN (low = condition test enabled)
SEQ_RLD  output  1  sequencer RLD (active-low)
SEQ_CI  output  1  sequencer carry-in
SEQ_OE  output  1  sequencer OE (active-low)
CS_REQ  output  1  control-store read request
CS_ADDR  output  12  control-store address
CS_DATA  input  CW_WIDTH  control-store read data
CS_VALID  input  1  CS_DATA valid; ends the request
CTRL  output  CW_WIDTH-19  user control field of the pipelined word
CTRL_STB  output  1  high during EXEC; CTRL is valid
BUSY  output  1  state is INIT, FETCH or EXEC
HALTED  output  1  state is HALTED
ERR  output  1  sticky fetch-timeout flag
EXEC_CNT  output  CNT_WIDTH  count of completed EXEC cycles, wraps

Behaviour:
- States: IDLE, INIT, FETCH, EXEC, HALTED, ERROR. All outputs are registered or decoded from the state and the pipeline register.
- Reset (async, any state, including mid-fetch) forces:
  - state IDLE; pipeline register 0; CS_ADDR 0; CS_REQ 0.
  - SEQ_I=4'hE, SEQ_CI=0, SEQ_RLD=1, SEQ_CCEN=1, SEQ_D=0, SEQ_OE=1.
  - CTRL_STB=0, ERR=0, EXEC_CNT=0.
- Hold drive (every state except INIT and EXEC): SEQ_I=4'hE (CONT), SEQ_CI=0, SEQ_RLD=1, SEQ_CCEN=1, SEQ_D=0. The sequencer's uPC, counter and stack are frozen.
- SEQ_OE is 0 in every state except IDLE.
- IDLE: on START go to INIT. STEP and HALT_REQ are ignored.
- INIT (1 cycle): drive SEQ_I=4'h0 (JZ), SEQ_CI=1. Latch Y_IN (expected 0) into CS_ADDR. Go to FETCH.
- FETCH:
  - CS_REQ=1, CS_ADDR stable.
  - On CS_VALID: load CS_DATA into the pipeline register, drop CS_REQ next cycle, go to EXEC. CS_VALID may arrive in the first FETCH cycle (zero-wait store).
  - Timeout counter clears on FETCH entry. After TIMEOUT cycles without CS_VALID, go to ERROR.
- EXEC (exactly 1 cycle):
  - SEQ_I/SEQ_D/SEQ_CCEN/SEQ_RLD come from the pipeline fields; SEQ_CI=1; CTRL_STB=1.
  - Latch Y_IN into CS_ADDR; EXEC_CNT increments.
  - Next state: HALTED if the HALT bit is set, HALT_REQ=1, or this EXEC was entered via STEP; otherwise FETCH.
- HALTED:
  - START goes to FETCH at the held CS_ADDR and clears step mode.
  - STEP goes to FETCH with step mode set.
  - If START and STEP are asserted together, START wins.
- ERROR: ERR=1, hold drive. Only RESET exits.
- CS_VALID outside FETCH is ignored.
- A latency of N wait cycles gives N+2 cycles per microword.
- EXEC_CNT wraps from all-ones to 0.

Test Plan:
- Reset, START; store returns word 0 = CONT with zero wait → INIT→FETCH(addr 0)→EXEC. CS_ADDR sequence is 0,1,2,…; EXEC_CNT=3 after 3 EXECs; SEQ_I=4'hE with SEQ_CI=0 in every FETCH cycle.
- Word at 5 = JP (I=4'h3) with D=12'h040 → next CS_ADDR=12'h040; CTRL_STB high for exactly one cycle per word.
- Store with 3 wait cycles → 5 cycles per microword; CS_REQ stays high exactly 4 cycles; pipeline register loads only on CS_VALID.
- HALT bit set in word at 2 → HALTED after its EXEC with CS_ADDR=3. STEP → one EXEC, back to HALTED, CS_ADDR=4. START → continuous run resumes from 4.
- CS_VALID never arrives with TIMEOUT=255 → ERROR after 255 FETCH cycles, ERR=1; START has no effect; RESET clears ERR.
- RESET asserted mid-FETCH → CS_REQ=0 immediately (asynchronously); state IDLE; EXEC_CNT=0; SEQ_OE=1.
